// File: rtl/servo_pwm_generator.sv
// servo_pwm_generator: 50 Hz hobby-servo PWM with push-button width control.
// A microsecond prescaler drives a period counter. The pulse width is held in
// a register that only changes at the period boundary, so every period has a
// clean, constant pulse. Button edges are collected as sticky requests and
// applied once per period, saturating at the configured width limits.

module servo_pwm_generator #(
  parameter int unsigned clk_freq_hz = 50000000,
  parameter int unsigned period_us   = 20000,
  parameter int unsigned min_width   = 500,
  parameter int unsigned max_width   = 2500,
  parameter int unsigned step_us     = 10,
  parameter int unsigned init_width  = 1500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        dec,
  output logic        pwm_out,
  output logic [15:0] width_output,
  output logic        tick
);

  localparam int unsigned CLKS_PER_US = clk_freq_hz / 1000000;
  localparam int unsigned PRE_W       = $clog2(CLKS_PER_US);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_US - 1);
  localparam logic [15:0]      US_LAST  = 16'(period_us - 1);
  localparam logic [16:0]      MIN_W    = 17'(min_width);
  localparam logic [16:0]      MAX_W    = 17'(max_width);
  localparam logic [16:0]      STEP     = 17'(step_us);
  localparam logic [15:0]      MIN_W16  = 16'(min_width);
  localparam logic [15:0]      MAX_W16  = 16'(max_width);
  localparam logic [15:0]      INIT_W   = 16'(init_width);

  logic [PRE_W-1:0] pre_cnt;
  logic             us_strobe;
  logic [15:0]      us_cnt;
  logic             boundary;

  logic [1:0]       inc_sync;
  logic [1:0]       dec_sync;
  logic             inc_prev;
  logic             dec_prev;
  logic             inc_rise;
  logic             dec_rise;
  logic             pend_inc;
  logic             pend_dec;

  logic [15:0]      width;
  logic [15:0]      width_next;
  logic [16:0]      sum_wide;
  logic [16:0]      diff_wide;

  assign us_strobe = (pre_cnt == PRE_LAST);
  assign boundary  = us_strobe && (us_cnt == US_LAST);

  assign inc_rise  = inc_sync[1] && !inc_prev;
  assign dec_rise  = dec_sync[1] && !dec_prev;

  // 17-bit arithmetic keeps the borrow/carry visible for clamping
  assign sum_wide  = {1'b0, width} + STEP;
  assign diff_wide = {1'b0, width} - STEP;

  assign width_output = width;

  // Microsecond prescaler: one strobe every CLKS_PER_US clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (us_strobe) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Period counter in microseconds, wrapping at the period boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt <= '0;
    end else if (boundary) begin
      us_cnt <= '0;
    end else if (us_strobe) begin
      us_cnt <= us_cnt + 16'd1;
    end
  end

  // Two-flop synchronizers plus the previous level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_sync <= '0;
      dec_sync <= '0;
      inc_prev <= 1'b0;
      dec_prev <= 1'b0;
    end else begin
      inc_sync <= {inc_sync[0], inc};
      dec_sync <= {dec_sync[0], dec};
      inc_prev <= inc_sync[1];
      dec_prev <= dec_sync[1];
    end
  end

  // Sticky requests; an edge coinciding with the boundary carries over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_inc <= 1'b0;
      pend_dec <= 1'b0;
    end else if (boundary) begin
      pend_inc <= inc_rise;
      pend_dec <= dec_rise;
    end else begin
      if (inc_rise) pend_inc <= 1'b1;
      if (dec_rise) pend_dec <= 1'b1;
    end
  end

  // Next width: a single clamped step, conflicting requests cancel out
  always_comb begin
    width_next = width;
    if (pend_inc && !pend_dec) begin
      width_next = (sum_wide > MAX_W) ? MAX_W16 : sum_wide[15:0];
    end else if (pend_dec && !pend_inc) begin
      width_next = (diff_wide[16] || (diff_wide < MIN_W)) ? MIN_W16 : diff_wide[15:0];
    end
  end

  // Width register and period tick, both updated on the boundary edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width <= INIT_W;
      tick  <= 1'b0;
    end else begin
      tick <= boundary;
      if (boundary) begin
        width <= width_next;
      end
    end
  end

  // Registered PWM compare against the period position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (us_cnt < width);
    end
  end

endmodule

// File: doc/servo_pwm_generator.md
# servo_pwm_generator

Generates the 50 Hz hobby-servo PWM that drives one arm joint and keeps the commanded pulse width, in microseconds, under push-button control. It sits directly upstream of the four-digit seven-segment display stage. `width_output` feeds that stage's 16-bit width input, and `tick` feeds its update strobe, so the display refreshes once per PWM period.

## Interface
- `clk_freq_hz`, default 50000000: system clock frequency. Must be an integer multiple of 1000000 and at least 2000000.
- `period_us`, default 20000: PWM period in µs. Must be ≤ 65535.
- `min_width`, default 500: lowest allowed pulse width in µs.
- `max_width`, default 2500: highest allowed pulse width in µs. Must satisfy min_width ≤ max_width < period_us.
- `step_us`, default 10: width change per accepted button press.
- `init_width`, default 1500: width after reset. Must lie within [min_width, max_width].

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inc`  in  1  active-high, asynchronous (button level); request to increase width.
- `dec`  in  1  active-high, asynchronous (button level); request to decrease width.
- `pwm_out`  out  1  servo PWM, registered.
- `width_output`  out  16  currently applied pulse width in µs, binary.
- `tick`  out  1  one-clk pulse at each period start.

## Operation
- Microsecond prescaler:
  - `pre_cnt` counts 0 .. clk_freq_hz/1000000 − 1 and then wraps.
  - `us_strobe` is asserted on the cycle where `pre_cnt` is at its terminal value.
- Period counter:
  - `us_cnt` (16 bits) increments on `us_strobe` and runs 0 .. period_us − 1.
  - `boundary` = `us_strobe` && `us_cnt` == period_us − 1.
- Button front end:
  - `inc` and `dec` each pass through a 2-flop synchronizer.
  - A rising edge on the synchronized level sets a sticky `pend_inc` / `pend_dec` flag.
  - Any number of edges within one period still yields one step.
- On `boundary`, all of the following happen on the same edge:
  - `us_cnt` ← 0.
  - Width update:
    - `pend_inc` only: width ← min(width + step_us, max_width).
    - `pend_dec` only: width ← max(width − step_us, min_width).
    - Both or neither: width unchanged.
  - Pending flags cleared. An edge detected on the same cycle as `boundary` is retained for the next boundary, not lost.
  - `tick` ← 1 for exactly one clk.
- Width arithmetic:
  - Computed in 17 bits before clamping, so neither overflow nor underflow can wrap.
  - `width_output` is the width register itself, so it changes only at boundaries.
- `pwm_out` ← (`us_cnt` < width), registered every clk. Width is constant within a period because it only changes at `boundary`.
- Reset (async assert, sync-free release):
  - Outputs: `pwm_out` = 0, `tick` = 0, `width_output` = init_width.
  - Internal state: `pre_cnt` = 0, `us_cnt` = 0, pending flags and synchronizers = 0.
- Reset mid-period aborts the period immediately. The first period after release starts at `us_cnt` = 0 with no `tick`; `tick` occurs only at wraps.

## Timing
- `pwm_out` is high for exactly width × (clk_freq_hz/1000000) clks per period. It rises 1 clk after `us_cnt` returns to 0.
- Period length is exactly period_us × (clk_freq_hz/1000000) clks.
- `tick` is high the clk after the `boundary` edge. `width_output` already holds the new value in that same cycle, so downstream logic latches the updated width.
- Button-to-`width_output` latency is 3 clks (sync + edge detect) plus the time to the next boundary, which is at most one period.
- `inc`/`dec` pulses shorter than 1 clk may be missed. Buttons are expected to be debounced upstream or held ≥ 1 clk; bounce produces at most one step per period.

## Test plan
Bench parameters: clk_freq_hz = 2000000, period_us = 100, min_width = 20, max_width = 80, step_us = 10, init_width = 50.

- **Reset, no input:**
  - `width_output` = 50.
  - `pwm_out` high for 100 clks of every 200-clk period.
  - `tick` high for 1 clk, first at 200 clks after release and every 200 clks thereafter.
- **Single inc:** one `inc` press mid-period → `width_output` = 60 at the next `tick`; the following period has 120 high clks.
- **Upper saturation:** 5 `inc` presses in separate periods → 60, 70, 80, 80, 80; `pwm_out` high time stays at 160 clks.
- **Lower saturation:** from 50, 4 `dec` presses → 40, 30, 20, 20.
- **Simultaneous and repeated presses:**
  - `inc` and `dec` rising in the same period → width unchanged.
  - Three `inc` edges in one period → +10 only.
  - `inc` edge on the `boundary` cycle → applied at the following boundary.
- **Mid-operation reset:** assert `rst_n` = 0 while `pwm_out` = 1 at width 70 → `pwm_out` = 0 and `width_output` = 50 immediately, with no `tick` until 200 clks after release.
